// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// Frames are sent back to back while the FIFO has data; SOut idles high.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (high); chains straight into START if more bytes are queued
module uart_transmitter #(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut,
  output logic       Busy
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             push;
  logic             pop;
  logic             shift_en;
  logic             bit_end;
  logic             fifo_empty;
  logic             sout_nxt;

  // Ready depends only on the registered occupancy, so a pop in the same
  // cycle can never let a push through a full FIFO.
  assign fifo_empty  = (occ == '0);
  assign DataInReady = (occ < OCC_FULL);
  assign push        = DataInValid && DataInReady;
  assign bit_end     = (bit_cnt == BIT_LAST);
  assign Busy        = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= DataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift_en  = 1'b0;
    sout_nxt  = SOut;
    case (state)
      IDLE: begin
        sout_nxt = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
          sout_nxt  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          sout_nxt  = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            sout_nxt  = 1'b1;
          end else begin
            sout_nxt = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
            sout_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
            sout_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        sout_nxt  = 1'b1;
      end
    endcase
  end

  // Bit timer restarts at every boundary; it sits at zero in IDLE so the
  // start bit gets a full period from the edge that pops the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      SOut    <= 1'b1;
    end else begin
      SOut <= sout_nxt;
      if (state == IDLE || bit_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (pop) begin
        shift <= fifo_mem[rd_ptr];
      end else if (shift_en) begin
        shift <= {1'b0, shift[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: the driver queues expected bytes on each accepted push, a
// line monitor decodes SOut frames, checks bit timing and compares bytes.
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       sout;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .DataIn     (data_in),
    .DataInValid(valid),
    .DataInReady(ready),
    .SOut       (sout),
    .Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    data_in = b;
    valid = 1'b1;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("push_timeout", 1, 0);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    exp_q.push_back(b);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 1, 0);
    repeat (5) @(negedge clk);
  endtask

  // Line monitor
  logic       m_ok;
  logic       m_stop_ok;
  logic       m_ab;
  logic       m_bit;
  logic [7:0] m_byte;
  logic [7:0] m_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sout === 1'b0) begin
        frame_starts.push_back(cyc);
        m_ok = 1'b1;
        m_stop_ok = 1'b1;
        m_ab = 1'b0;
        m_byte = '0;
        m_bit = 1'b0;
        for (int s = 1; s < 10; s++) begin
          @(negedge clk);
          if (!rst_n) begin m_ab = 1'b1; break; end
          if (sout !== 1'b0) m_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          if (m_ab) break;
          for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (!rst_n) begin m_ab = 1'b1; break; end
            if (s == 0) m_bit = sout;
            else if (sout !== m_bit) m_ok = 1'b0;
          end
          m_byte[b] = m_bit;
        end
        for (int s = 0; s < 10; s++) begin
          if (m_ab) break;
          @(negedge clk);
          if (!rst_n) begin m_ab = 1'b1; break; end
          if (sout !== 1'b1) m_stop_ok = 1'b0;
        end
        if (!m_ab) begin
          check("bit_stable", m_ok, 1);
          check("stop_bit", m_stop_ok, 1);
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            check("frame_byte", m_byte, m_exp);
          end
        end
      end
    end
  end

  int   acc;
  int   accs[6];
  int   base;
  int   n;
  logic saw_ready;
  logic [7:0] burst[6];

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_sout", sout, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte, latency and Busy duration
    push_byte(8'hA5, acc);
    check("a5_not_early", sout, 1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (n == 0) check("a5_start_low", sout, 0);
      if (!busy) break;
      n++;
    end
    check("a5_busy_cycles", n, 100);
    wait_drain();

    // Back-to-back frames
    base = frame_starts.size();
    push_byte(8'h00, acc);
    push_byte(8'hFF, acc);
    wait_drain();
    check("b2b_frames", frame_starts.size() - base, 2);
    if (frame_starts.size() - base == 2)
      check("b2b_gap", frame_starts[base+1] - frame_starts[base], 100);

    // FIFO fill with continuous valid
    burst = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    for (int i = 0; i < 6; i++) begin
      push_byte(burst[i], accs[i]);
      if (i == 4) check("full_ready_low", ready, 0);
    end
    check("fill_consecutive", accs[4] - accs[0], 4);
    check("sixth_accept", accs[5] - accs[0], 102);
    wait_drain();

    // Data offered while full is ignored
    push_byte(8'h81, acc);
    push_byte(8'h42, acc);
    push_byte(8'h24, acc);
    push_byte(8'h18, acc);
    push_byte(8'hE7, acc);
    data_in = 8'h77;
    valid = 1'b1;
    saw_ready = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    valid = 1'b0;
    data_in = 8'h00;
    check("full_refuse", saw_ready, 0);
    wait_drain();

    // Reset mid-frame during data bit 3
    push_byte(8'h3C, acc);
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    repeat (42) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sout", sout, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = frame_starts.size();
    repeat (300) @(negedge clk);
    check("rst_no_frames", frame_starts.size() - base, 0);
    check("rst_idle_busy", busy, 0);

    // First push after reset
    push_byte(8'h5A, acc);
    check("post_rst_not_early", sout, 1);
    @(negedge clk);
    check("post_rst_start_low", sout, 0);
    wait_drain();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
- REQ-001: Parameter CLOCK_FREQ, default 33_000_000, meaning system clock frequency in Hz.
- REQ-002: Parameter BAUD_RATE, default 115_200, meaning serial line bit rate in bits/s.
- REQ-003: Parameter FIFO_DEPTH, default 4, meaning number of byte entries in the transmit FIFO; the value SHALL be a power of two and at least 2.
- REQ-004: clk  input  1  system clock; all state SHALL update on the rising edge.
- REQ-005: rst_n  input  1  reset; asynchronous, active-low.
- REQ-006: DataIn  input  8  byte offered by the CPU memory map for transmission.
- REQ-007: DataInValid  input  1  DataIn is valid this cycle.
- REQ-008: DataInReady  output  1  block can accept a byte this cycle.
- REQ-009: SOut  output  1  serial line; idle level is high.
- REQ-010: Busy  output  1  a frame is in progress or the FIFO is non-empty.

Function
- REQ-011: Bit period SHALL be SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE cycles, using integer division that truncates the result.
- REQ-012: Each frame SHALL be 8N1: one start bit (0), data bits D0..D7 sent LSB first, then one stop bit (1); the frame is 10 bit periods long.
- REQ-013: Every bit SHALL be held on SOut for exactly SYMBOL_EDGE_TIME cycles; the bit counter SHALL reload to 0 at each bit boundary with no slip.
- REQ-014: A byte SHALL be accepted on a rising edge where DataInValid and DataInReady are both 1; no transfer occurs otherwise.
- REQ-015: DataInReady SHALL be 1 exactly when the FIFO occupancy count is less than FIFO_DEPTH, and it SHALL be driven from registered state only (no combinational path from DataInValid).
- REQ-016: When the FIFO is full, DataInReady SHALL be 0 and the push SHALL be refused; a pop in the same cycle SHALL NOT enable that push (no pass-through).
- REQ-017: When the FIFO is non-empty, a push and a pop in the same cycle SHALL leave the occupancy count unchanged and preserve FIFO order.
- REQ-018: FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy counter of width log2(FIFO_DEPTH)+1.
- REQ-019: FSM states: IDLE, START, DATA, STOP.
- REQ-020: IDLE -> START on the edge where the FIFO is non-empty; on that same edge the head byte SHALL be popped into the shift register.
- REQ-021: START -> DATA after one bit period.
- REQ-022: DATA -> STOP after 8 bit periods; the shift register SHALL shift right once per bit boundary.
- REQ-023: STOP -> START (with a pop) if the FIFO is non-empty at the end of the stop bit, so back-to-back frames have no idle gap; otherwise STOP -> IDLE.
- REQ-024: SOut SHALL be a registered output: 1 in IDLE and STOP, 0 in START, and the shift-register LSB in DATA.
- REQ-025: Latency: a byte pushed on edge N into an empty FIFO with the FSM in IDLE SHALL drive SOut low from edge N+1.
- REQ-026: Busy SHALL be 1 when the state is not IDLE or the FIFO is non-empty, and 0 otherwise.
- REQ-027: DataIn values presented while DataInReady is 0 SHALL be ignored and SHALL NOT corrupt queued data.

Reset
- REQ-028: While rst_n is low, the following SHALL hold: state=IDLE, SOut=1, FIFO empty, pointers=0, counters=0, DataInReady=1, Busy=0.
- REQ-029: Reset asserted mid-frame SHALL immediately drive SOut=1 without waiting for a clock edge, and SHALL discard the current frame and all queued bytes.
- REQ-030: After rst_n is deasserted, the first push SHALL behave exactly as REQ-025 specifies.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so 10 cycles per bit)
- REQ-031: Push 0xA5 while idle -> SOut low from the next edge for 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high for 10 cycles; Busy returns to 0 exactly 100 cycles after the start bit begins.
- REQ-032: Push 0x00 and then 0xFF on consecutive cycles -> two frames with no idle gap between them; the 0xFF start bit begins on the cycle after the first stop bit ends.
- REQ-033: Hold DataInValid=1 with 6 distinct bytes during a frame -> DataInReady drops to 0 after the 5th accepted byte (1 in flight plus 4 queued); the 6th byte is accepted only once space frees, and all bytes are sent in order.
- REQ-034: Pulse rst_n low during DATA bit 3 of 0x3C with 2 bytes queued -> SOut=1 immediately, Busy=0, DataInReady=1, and no further frames are sent after release.
- REQ-035: Present DataInValid=1 while the FIFO is full with 0x77 on DataIn -> 0x77 is never transmitted, and the queued bytes are transmitted unchanged.
- REQ-036: Line monitor check across all scenarios -> each bit period measures exactly 10 cycles and SOut never glitches within a bit.
